// File: rtl/phy_rx_serial_paralelo.sv
// Receive-side serial-to-parallel converter for one PHY lane: comma hunt,
// byte alignment, link qualification after a run of commas, byte delivery.
module phy_rx_serial_paralelo #(
    parameter logic [7:0]  COMMA        = 8'hBC,
    parameter int unsigned BC_THRESHOLD = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active,
    output logic       aligned
);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGNED,
        ACTIVE
    } state_t;

    localparam logic [3:0] THRESH = 4'(BC_THRESHOLD);

    state_t     state;
    logic [7:0] shift_reg;
    logic [7:0] shift_nxt;
    logic [2:0] bit_cnt;
    logic [3:0] bc_count;
    logic [3:0] bc_inc;

    always_comb begin
        shift_nxt = {shift_reg[6:0], serial_in};
        bc_inc    = bc_count + 4'd1;
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state       <= SEARCH;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            bc_count    <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
            aligned     <= 1'b0;
        end else begin
            shift_reg   <= shift_nxt;
            byte_strobe <= 1'b0;
            case (state)
                SEARCH: begin
                    if (shift_nxt == COMMA) begin
                        bit_cnt  <= '0;
                        bc_count <= 4'd1;
                        aligned  <= 1'b1;
                        if (THRESH == 4'd1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= ALIGNED;
                        end
                    end
                end
                ALIGNED: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_strobe <= 1'b1;
                        if (shift_nxt == COMMA) begin
                            bc_count <= bc_inc;
                            if (bc_inc == THRESH) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            // Comma seen in SEARCH was not a real byte boundary.
                            state    <= SEARCH;
                            bc_count <= '0;
                            aligned  <= 1'b0;
                        end
                    end
                end
                ACTIVE: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_strobe <= 1'b1;
                        if (shift_nxt != COMMA) begin
                            data_out  <= shift_nxt;
                            valid_out <= 1'b1;
                        end else begin
                            valid_out <= 1'b0;
                        end
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: doc/phy_rx_serial_paralelo.md
Name: phy_rx_serial_paralelo

Overview:
Receive-side serial-to-parallel converter for one PHY lane. It sits at the far end of the phy_tx serial link, driven by the lane's serial bit stream in the clk_32f domain. It finds byte alignment by hunting for the comma byte, declares the link active after a run of consecutive commas, and then delivers each received data byte with a valid flag and a one-cycle strobe. Four instances, one per lane, feed the downstream receive byte-unstriping logic.

Parameters:
COMMA, 8'hBC, idle/alignment byte the transmitter sends whenever its lane has no valid data.
BC_THRESHOLD, 4, number of consecutive aligned commas required before `active` is asserted. Legal range 1..15.

Ports:
clk_32f  input  1  bit-rate clock; one serial bit is sampled per rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
serial_in  input  1  serial data, MSB of each byte first.
data_out  output  8  last received non-comma byte.
valid_out  output  1  high for the byte period following a non-comma byte while active.
byte_strobe  output  1  one-cycle pulse at each aligned byte boundary.
active  output  1  link aligned and qualified; drives `active_serial` back toward the Tx side.
aligned  output  1  byte boundary locked (state ALIGNED or ACTIVE).

Behaviour:
- Reset values (asynchronous, while reset=1):
  - shift_reg = 0, bit_cnt = 0, bc_count = 0, state = SEARCH.
  - data_out = 8'h00; valid_out, byte_strobe, active and aligned = 0.
- Shift: every edge, `shift_nxt = {shift_reg[6:0], serial_in}`, and shift_reg <= shift_nxt.
- States:
  - **SEARCH**: bit-by-bit hunt. When shift_nxt == COMMA:
    - go to ALIGNED, bc_count <= 1, bit_cnt <= 0;
    - if BC_THRESHOLD == 1, go directly to ACTIVE instead.
    - byte_strobe stays 0 in SEARCH.
  - **ALIGNED**: bit_cnt counts 0..7, wraps 7→0. When bit_cnt == 7, byte = shift_nxt and byte_strobe <= 1.
    - If byte == COMMA: bc_count <= bc_count + 1. When bc_count + 1 == BC_THRESHOLD, go to ACTIVE and active <= 1 on that same edge.
    - If byte != COMMA: go to SEARCH and bc_count <= 0. This is a false-comma recovery; valid_out stays 0 and data_out is unchanged.
  - **ACTIVE**: byte boundary as in ALIGNED. At each bit_cnt == 7 edge, byte_strobe <= 1 and:
    - byte != COMMA: data_out <= byte, valid_out <= 1.
    - byte == COMMA: valid_out <= 0, data_out holds its previous value.
    - valid_out holds its value between boundaries (8 cycles).
    - ACTIVE is sticky; only reset leaves it.
- byte_strobe is 1 for exactly one cycle per aligned byte, and 0 on all other edges.
- aligned = 1 in ALIGNED and ACTIVE.
- Latency: data_out and valid_out update on the same edge that samples the byte's LSB, so they are visible 0 cycles after the last bit's edge (registered outputs).
- bc_count saturates at BC_THRESHOLD. No overflow is possible; 4 bits are sufficient.
- Reset asserted mid-byte or while ACTIVE: all outputs go to their reset values immediately, without waiting for a clock edge. After release, the block restarts in SEARCH and partial bits are discarded.
- A comma that spans a byte boundary while ALIGNED or ACTIVE is not re-evaluated; alignment is only re-searched from SEARCH.

Test Plan:
1. Reset, then serial 0xBC ×4 MSB-first starting at a random bit offset after 3 junk bits (101) → aligned=1 after the first BC's last bit; active=1 on the 4th BC's last-bit edge; valid_out=0 throughout; 3 byte_strobe pulses (bytes 2–4).
2. After test 1, send 0xEE, 0x01, 0xFF, 0xFD → data_out=EE,01,FF,FD on successive strobes, 8 cycles apart, with valid_out=1 on each.
3. While active, send 0x05 then 0xBC then 0x06 → data_out=05, valid_out=1; then valid_out=0 with data_out held at 05; then data_out=06, valid_out=1.
4. False lock: 0xBC, 0xBC, then 0x3C → aligned drops to 0 after 0x3C, active stays 0, bc_count restarts; then 4×0xBC → active=1.
5. Assert reset mid-byte while active (bit_cnt=3), independent of the clock edge → data_out=00, valid_out, active and aligned = 0 immediately; 4×0xBC after release → active=1 again.
6. Compile with BC_THRESHOLD=1: a single 0xBC → active=1 on its last-bit edge; the next byte 0x7A → data_out=7A, valid_out=1.
